riscv_core: RTL and testbench

//   5-stage pipelined RV32I-subset CPU (IF/ID/EX/MEM/WB) with on-chip instruction and data memories.
//   Top-level processor block. Exposes the write-back data and the data-memory address for observation.

---
 rtl/riscv_core.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_riscv_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core.sv
// riscv_core -- 5-stage pipelined RV32I-subset CPU (IF/ID/EX/MEM/WB).
//   Ports: clk (rising edge), reset (async, active low),
//          WB_Data (value written to the regfile by the WB-stage instruction, 0 if none),
//          Address (ALU result of the MEM-stage instruction).
//   Optional feature macro: FORWARDING_EN (EX/MEM and MEM/WB -> EX operand forwarding).
//   Without it, ID stalls on any RAW dependency on an instruction in EX or MEM.
//   The instruction memory is preloaded into dp.instr_mem.Inst_mem (hex words, one per line).

// Instruction ROM: combinational word read.
module riscv_imem #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic [$clog2(IMEM_DEPTH)-1:0] addr_i,
  output logic [31:0]                   data_o
);
  logic [31:0] Inst_mem [IMEM_DEPTH];
  assign data_o = Inst_mem[addr_i];
endmodule

module riscv_datapath #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] wb_data_o,
  output logic [31:0] address_o
);
  localparam int          IA      = $clog2(IMEM_DEPTH);
  localparam int          DA      = $clog2(DMEM_DEPTH);
  localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);
  localparam logic [31:0] NOP     = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_e;
  typedef struct packed {
    logic    reg_write;  // only set when rd != x0
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    branch_ne;
    logic    jump;
    logic    alu_src_imm;
    alu_op_e alu_op;
  } ctrl_t;
  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
`ifdef FORWARDING_EN
    logic [4:0]  rs1;
    logic [4:0]  rs2;
`endif
  } idex_t;

  // ---------------- state ----------------
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc_q, ifid_pc_d;
  idex_t       idex_q, idex_d;
  logic [31:0] exmem_alu_q, exmem_store_q;
  logic [4:0]  exmem_rd_q;
  logic        exmem_we_q, exmem_mem_read_q, exmem_mem_write_q;
  logic [31:0] memwb_data_q, memwb_data_d;
  logic [4:0]  memwb_rd_q;
  logic        memwb_we_q;
  logic [31:0] rf_q [32];
  logic [31:0] dmem [DMEM_DEPTH];

  // ---------------- IF ----------------
  logic [31:0] if_instr;
  riscv_imem #(.IMEM_DEPTH(IMEM_DEPTH)) instr_mem (.addr_i(pc_q[IA+1:2]), .data_o(if_instr));

  // ---------------- ID ----------------
  logic [6:0]  id_op, id_f7;
  logic [2:0]  id_f3;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm, id_rs1_val, id_rs2_val;
  ctrl_t       id_ctrl;
  logic        id_use_rs1, id_use_rs2, id_valid;

  assign id_op  = ifid_instr_q[6:0];
  assign id_rd  = ifid_instr_q[11:7];
  assign id_f3  = ifid_instr_q[14:12];
  assign id_rs1 = ifid_instr_q[19:15];
  assign id_rs2 = ifid_instr_q[24:20];
  assign id_f7  = ifid_instr_q[31:25];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    id_ctrl    = '0;
    id_imm     = '0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    id_valid   = 1'b1;
    unique case (id_op)
      7'b0110011: begin  // R-type
        id_ctrl.reg_write = 1'b1;
        id_use_rs1 = 1'b1;
        id_use_rs2 = 1'b1;
        id_valid = (id_f7 == 7'h00) || (id_f7 == 7'h20 && id_f3 == 3'b000);
        case (id_f3)
          3'b000:  id_ctrl.alu_op = id_f7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  id_ctrl.alu_op = ALU_SLL;
          3'b010:  id_ctrl.alu_op = ALU_SLT;
          3'b100:  id_ctrl.alu_op = ALU_XOR;
          3'b101:  id_ctrl.alu_op = ALU_SRL;
          3'b110:  id_ctrl.alu_op = ALU_OR;
          3'b111:  id_ctrl.alu_op = ALU_AND;
          default: id_valid = 1'b0;
        endcase
      end
      7'b0010011: begin  // I-type ALU
        id_ctrl.reg_write   = 1'b1;
        id_ctrl.alu_src_imm = 1'b1;
        id_use_rs1 = 1'b1;
        id_imm = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
        case (id_f3)
          3'b000:  id_ctrl.alu_op = ALU_ADD;
          3'b010:  id_ctrl.alu_op = ALU_SLT;
          3'b100:  id_ctrl.alu_op = ALU_XOR;
          3'b110:  id_ctrl.alu_op = ALU_OR;
          3'b111:  id_ctrl.alu_op = ALU_AND;
          default: id_valid = 1'b0;
        endcase
      end
      7'b0000011: begin  // lw
        id_ctrl.reg_write   = 1'b1;
        id_ctrl.mem_read    = 1'b1;
        id_ctrl.alu_src_imm = 1'b1;
        id_use_rs1 = 1'b1;
        id_imm   = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
        id_valid = (id_f3 == 3'b010);
      end
      7'b0100011: begin  // sw
        id_ctrl.mem_write   = 1'b1;
        id_ctrl.alu_src_imm = 1'b1;
        id_use_rs1 = 1'b1;
        id_use_rs2 = 1'b1;
        id_imm   = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
        id_valid = (id_f3 == 3'b010);
      end
      7'b1100011: begin  // beq / bne
        id_ctrl.branch    = 1'b1;
        id_ctrl.branch_ne = id_f3[0];
        id_use_rs1 = 1'b1;
        id_use_rs2 = 1'b1;
        id_imm   = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                    ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
        id_valid = (id_f3[2:1] == 2'b00);
      end
      7'b1101111: begin  // jal
        id_ctrl.reg_write = 1'b1;
        id_ctrl.jump      = 1'b1;
        id_imm = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                  ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};
      end
      default: id_valid = 1'b0;
    endcase
    if (!id_valid) begin
      id_ctrl    = '0;
      id_use_rs1 = 1'b0;
      id_use_rs2 = 1'b0;
    end
    id_ctrl.reg_write = id_ctrl.reg_write && (id_rd != 5'd0);
    id_use_rs1 = id_use_rs1 && (id_rs1 != 5'd0);
    id_use_rs2 = id_use_rs2 && (id_rs2 != 5'd0);
  end

  // Write-first regfile: a WB write in this cycle is seen by the ID read.
  assign id_rs1_val = (id_rs1 == 5'd0) ? 32'h0 :
                      (memwb_we_q && memwb_rd_q == id_rs1) ? memwb_data_q : rf_q[id_rs1];
  assign id_rs2_val = (id_rs2 == 5'd0) ? 32'h0 :
                      (memwb_we_q && memwb_rd_q == id_rs2) ? memwb_data_q : rf_q[id_rs2];

  // ---------------- hazard detection ----------------
  logic ex_hit, stall;
  assign ex_hit = idex_q.ctrl.reg_write &&
                  ((id_use_rs1 && idex_q.rd == id_rs1) || (id_use_rs2 && idex_q.rd == id_rs2));
`ifdef FORWARDING_EN
  assign stall = idex_q.ctrl.mem_read && ex_hit;  // load-use only
`else
  logic mem_hit;
  assign mem_hit = exmem_we_q &&
                   ((id_use_rs1 && exmem_rd_q == id_rs1) || (id_use_rs2 && exmem_rd_q == id_rs2));
  assign stall = ex_hit || mem_hit;
`endif

  // ---------------- EX ----------------
  logic [31:0] ex_a, ex_b_reg, ex_b, ex_alu, ex_result, ex_target;
  logic        ex_take;

`ifdef FORWARDING_EN
  // EX/MEM has priority; a load in EX/MEM holds an address, never data.
  assign ex_a = (exmem_we_q && !exmem_mem_read_q && exmem_rd_q == idex_q.rs1 && idex_q.rs1 != 5'd0) ? exmem_alu_q :
                (memwb_we_q && memwb_rd_q == idex_q.rs1 && idex_q.rs1 != 5'd0) ? memwb_data_q : idex_q.rs1_val;
  assign ex_b_reg = (exmem_we_q && !exmem_mem_read_q && exmem_rd_q == idex_q.rs2 && idex_q.rs2 != 5'd0) ? exmem_alu_q :
                    (memwb_we_q && memwb_rd_q == idex_q.rs2 && idex_q.rs2 != 5'd0) ? memwb_data_q : idex_q.rs2_val;
`else
  assign ex_a     = idex_q.rs1_val;
  assign ex_b_reg = idex_q.rs2_val;
`endif
  assign ex_b = idex_q.ctrl.alu_src_imm ? idex_q.imm : ex_b_reg;

  always_comb begin
    unique case (idex_q.ctrl.alu_op)
      ALU_ADD: ex_alu = ex_a + ex_b;
      ALU_SUB: ex_alu = ex_a - ex_b;
      ALU_AND: ex_alu = ex_a & ex_b;
      ALU_OR:  ex_alu = ex_a | ex_b;
      ALU_XOR: ex_alu = ex_a ^ ex_b;
      ALU_SLT: ex_alu = {31'b0, $signed(ex_a) < $signed(ex_b)};
      ALU_SLL: ex_alu = ex_a << ex_b[4:0];
      ALU_SRL: ex_alu = ex_a >> ex_b[4:0];
      default: ex_alu = ex_a + ex_b;
    endcase
  end

  assign ex_take   = idex_q.ctrl.jump ||
                     (idex_q.ctrl.branch && ((ex_a == ex_b_reg) != idex_q.ctrl.branch_ne));
  assign ex_target = (idex_q.pc + idex_q.imm) & PC_MASK;
  assign ex_result = idex_q.ctrl.jump ? idex_q.pc + 32'd4 : ex_alu;

  // ---------------- MEM ----------------
  logic [31:0] mem_rdata;
  assign mem_rdata    = dmem[exmem_alu_q[DA+1:2]];
  assign memwb_data_d = !exmem_we_q ? 32'h0 : (exmem_mem_read_q ? mem_rdata : exmem_alu_q);

  // ---------------- next state ----------------
  // A taken branch/jump overrides a simultaneous stall: the stalled ID instruction is flushed anyway.
  always_comb begin
    pc_d         = (pc_q + 32'd4) & PC_MASK;
    ifid_instr_d = if_instr;
    ifid_pc_d    = pc_q;
    idex_d       = '0;
    if (ex_take) begin
      pc_d         = ex_target;
      ifid_instr_d = NOP;
      ifid_pc_d    = '0;
    end else if (stall) begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
    end else begin
      idex_d.ctrl    = id_ctrl;
      idex_d.pc      = ifid_pc_q;
      idex_d.rs1_val = id_rs1_val;
      idex_d.rs2_val = id_rs2_val;
      idex_d.imm     = id_imm;
      idex_d.rd      = id_rd;
`ifdef FORWARDING_EN
      idex_d.rs1     = id_rs1;
      idex_d.rs2     = id_rs2;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q              <= RESET_PC;
      ifid_instr_q      <= NOP;
      ifid_pc_q         <= '0;
      idex_q            <= '0;
      exmem_alu_q       <= '0;
      exmem_store_q     <= '0;
      exmem_rd_q        <= '0;
      exmem_we_q        <= 1'b0;
      exmem_mem_read_q  <= 1'b0;
      exmem_mem_write_q <= 1'b0;
      memwb_data_q      <= '0;
      memwb_rd_q        <= '0;
      memwb_we_q        <= 1'b0;
    end else begin
      pc_q              <= pc_d;
      ifid_instr_q      <= ifid_instr_d;
      ifid_pc_q         <= ifid_pc_d;
      idex_q            <= idex_d;
      exmem_alu_q       <= ex_result;
      exmem_store_q     <= ex_b_reg;
      exmem_rd_q        <= idex_q.rd;
      exmem_we_q        <= idex_q.ctrl.reg_write;
      exmem_mem_read_q  <= idex_q.ctrl.mem_read;
      exmem_mem_write_q <= idex_q.ctrl.mem_write;
      memwb_data_q      <= memwb_data_d;
      memwb_rd_q        <= exmem_rd_q;
      memwb_we_q        <= exmem_we_q;
    end
  end

  // NOTE: the regfile is built from flops and cleared on reset; the data RAM below has no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (memwb_we_q) begin
      rf_q[memwb_rd_q] <= memwb_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (exmem_mem_write_q) dmem[exmem_alu_q[DA+1:2]] <= exmem_store_q;
  end

  assign wb_data_o = memwb_data_q;
  assign address_o = exmem_alu_q;
endmodule

module riscv_core #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WB_Data,
  output logic [31:0] Address
);
  riscv_datapath #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .DMEM_DEPTH(DMEM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dp (
    .clk      (clk),
    .rst_n    (reset),
    .wb_data_o(WB_Data),
    .address_o(Address)
  );
endmodule

// File: tb/tb_riscv_core.sv
// tb_riscv_core -- directed, table-driven bench for riscv_core.
//   Three small programs are loaded into dp.instr_mem.Inst_mem while reset is held;
//   WB_Data / Address are sampled on the falling edge after each rising edge.
//   Sample k = the falling edge after the k-th rising edge following reset release.
module tb_riscv_core;
  logic        clk;
  logic        reset;
  logic [31:0] WB_Data;
  logic [31:0] Address;

  riscv_core dut (.clk(clk), .reset(reset), .WB_Data(WB_Data), .Address(Address));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    int          prog;
    int          cyc;
    logic [31:0] wb;
    logic [31:0] addr;
    bit          chk_addr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] progs [3][16];
  int          n_tests = 0;
  int          n_fail  = 0;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic void add_vec(int p, int c, logic [31:0] wb, logic [31:0] addr, bit ca);
    vec_t v;
    v.prog = p; v.cyc = c; v.wb = wb; v.addr = addr; v.chk_addr = ca;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_prog(int p);
    for (int i = 0; i < 256; i++) dut.dp.instr_mem.Inst_mem[i] = NOP;
    for (int i = 0; i < 16; i++) dut.dp.instr_mem.Inst_mem[i] = progs[p][i];
  endtask

  task automatic apply_reset(int p);
    @(negedge clk);
    reset = 1'b0;
    load_prog(p);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_prog(int p, int n);
    for (int s = 1; s <= n; s++) begin
      tick();
      foreach (vecs[k]) begin
        if (vecs[k].prog == p && vecs[k].cyc == s) begin
          check($sformatf("p%0d_s%0d_wb", p, s), WB_Data, vecs[k].wb);
          if (vecs[k].chk_addr) check($sformatf("p%0d_s%0d_addr", p, s), Address, vecs[k].addr);
        end
      end
    end
  endtask

  initial begin
    // ---------------- programs ----------------
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) progs[p][i] = NOP;
    // p0: addi x1,x0,5; addi x2,x0,7; add x3,x1,x2
    progs[0][0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    progs[0][1] = enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);
    progs[0][2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    // p1: addi x1,x0,0x40; sw x1,0(x1); lw x2,0(x1); add x3,x2,x2
    progs[1][0] = enc_i(12'h040, 5'd0, 3'b000, 5'd1, 7'b0010011);
    progs[1][1] = enc_s(12'd0, 5'd1, 5'd1);
    progs[1][2] = enc_i(12'd0, 5'd1, 3'b010, 5'd2, 7'b0000011);
    progs[1][3] = enc_r(7'h00, 5'd2, 5'd2, 3'b000, 5'd3);
    // p2: beq skip / bne fall-through / x0 writes / jal skip
    progs[2][0] = enc_b(13'd8, 5'd0, 5'd0, 3'b000);               // beq x0,x0,+8
    progs[2][1] = enc_i(12'd1, 5'd0, 3'b000, 5'd5, 7'b0010011);   // addi x5,x0,1 (flushed)
    progs[2][2] = enc_b(13'd8, 5'd0, 5'd0, 3'b001);               // bne x0,x0,+8 (not taken)
    progs[2][3] = enc_i(12'd3, 5'd0, 3'b000, 5'd6, 7'b0010011);   // addi x6,x0,3
    progs[2][4] = enc_r(7'h00, 5'd6, 5'd5, 3'b000, 5'd7);         // add x7,x5,x6 -> 3
    progs[2][5] = enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011);   // addi x0,x0,9
    progs[2][6] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd4);         // add x4,x0,x0
    progs[2][7] = enc_j(21'd8, 5'd8);                             // jal x8,+8 -> x8=0x20
    progs[2][8] = enc_i(12'h055, 5'd0, 3'b000, 5'd9, 7'b0010011); // addi x9 (flushed)
    progs[2][9] = enc_r(7'h00, 5'd0, 5'd8, 3'b000, 5'd11);        // add x11,x8,x0 -> 0x20

    // ---------------- expected samples ----------------
    add_vec(0, 3, 32'd0, 32'd5, 1);
    add_vec(0, 4, 32'd5, 32'd7, 1);
`ifdef FORWARDING_EN
    add_vec(0, 5, 32'd7, 32'd12, 1);
    add_vec(0, 6, 32'd12, 32'd0, 0);

    add_vec(1, 3, 32'd0,    32'h40, 1);
    add_vec(1, 4, 32'h40,   32'h40, 1);
    add_vec(1, 5, 32'd0,    32'h40, 1);
    add_vec(1, 6, 32'h40,   32'd0,  1);
    add_vec(1, 7, 32'd0,    32'h80, 1);
    add_vec(1, 8, 32'h80,   32'd0,  0);

    add_vec(2, 4,  32'd0,  32'd0,  0);
    add_vec(2, 5,  32'd0,  32'd0,  0);
    add_vec(2, 6,  32'd0,  32'd0,  0);
    add_vec(2, 7,  32'd0,  32'd3,  1);
    add_vec(2, 8,  32'd3,  32'd3,  1);
    add_vec(2, 9,  32'd3,  32'd9,  1);
    add_vec(2, 10, 32'd0,  32'd0,  1);
    add_vec(2, 11, 32'd0,  32'h20, 1);
    add_vec(2, 12, 32'h20, 32'd0,  0);
    add_vec(2, 13, 32'd0,  32'd0,  0);
    add_vec(2, 14, 32'd0,  32'd0,  0);
    add_vec(2, 15, 32'h20, 32'd0,  0);
`else
    add_vec(0, 5, 32'd7,  32'd0,  1);
    add_vec(0, 6, 32'd0,  32'd0,  0);
    add_vec(0, 7, 32'd0,  32'd12, 1);
    add_vec(0, 8, 32'd12, 32'd0,  0);

    add_vec(1, 3,  32'd0,  32'h40, 1);
    add_vec(1, 4,  32'h40, 32'd0,  0);
    add_vec(1, 5,  32'd0,  32'd0,  1);
    add_vec(1, 6,  32'd0,  32'h40, 1);
    add_vec(1, 7,  32'd0,  32'h40, 1);
    add_vec(1, 8,  32'h40, 32'd0,  1);
    add_vec(1, 9,  32'd0,  32'd0,  1);
    add_vec(1, 10, 32'd0,  32'h80, 1);
    add_vec(1, 11, 32'h80, 32'd0,  0);

    add_vec(2, 5,  32'd0,  32'd0,  0);
    add_vec(2, 6,  32'd0,  32'd0,  0);
    add_vec(2, 7,  32'd0,  32'd3,  1);
    add_vec(2, 8,  32'd3,  32'd0,  0);
    add_vec(2, 9,  32'd0,  32'd0,  0);
    add_vec(2, 10, 32'd0,  32'd3,  1);
    add_vec(2, 11, 32'd3,  32'd9,  1);
    add_vec(2, 12, 32'd0,  32'd0,  1);
    add_vec(2, 13, 32'd0,  32'h20, 1);
    add_vec(2, 14, 32'h20, 32'd0,  0);
    add_vec(2, 15, 32'd0,  32'd0,  0);
    add_vec(2, 16, 32'd0,  32'd0,  0);
    add_vec(2, 17, 32'h20, 32'd0,  0);
`endif

    // ---------------- reset state ----------------
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_wb",   WB_Data, 32'd0);
    check("reset_addr", Address, 32'd0);

    // ---------------- table-driven programs ----------------
    for (int p = 0; p < 3; p++) begin
      apply_reset(p);
      run_prog(p, 20);
    end

    // ---------------- reset asserted mid-program ----------------
    apply_reset(0);
    run_prog(0, 5);                // WB_Data shows 7 at sample 5
    #3 reset = 1'b0;
    #1;
    check("midreset_wb",   WB_Data, 32'd0);
    check("midreset_addr", Address, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_prog(0, 12);               // restart from RESET_PC, same results as the first run

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
